// File: rtl/beat_timing_gen.sv
// Beat/phase sequencer: rotates T1..T3 phases within W1..W3 beats, honouring the
// controller's SHORT/LONG/STOP requests, with console start, stepping and a cycle counter.
module beat_timing_gen #(
   parameter int unsigned CYC_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             qd,
   input  logic             step,
   input  logic             short,
   input  logic             long,
   input  logic             stop,
   output logic [2:0]       t,
   output logic [2:0]       w,
   output logic             run,
   output logic [CYC_W-1:0] cyc
);

   typedef enum logic [0:0] {StHalt, StExec} state_e;

   state_e     state;
   // Set when QD was low at the previous edge; cleared by reset so a QD already
   // high at reset release cannot start the machine.
   logic       qd_low;
   logic [2:0] w_nxt;
   logic       done;
   logic       beat_end;

   assign beat_end = (t == 3'b100);

   always_comb begin
      w_nxt = 3'b001;
      done  = 1'b0;
      case (w)
         3'b001: begin
            if (short) begin
               w_nxt = 3'b001;
               done  = 1'b1;
            end else begin
               w_nxt = 3'b010;
            end
         end
         3'b010: begin
            if (long) begin
               w_nxt = 3'b100;
            end else begin
               w_nxt = 3'b001;
               done  = 1'b1;
            end
         end
         default: begin
            w_nxt = 3'b001;
            done  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state  <= StHalt;
         t      <= 3'b000;
         w      <= 3'b001;
         run    <= 1'b0;
         cyc    <= '0;
         qd_low <= 1'b0;
      end else begin
         qd_low <= ~qd;
         case (state)
            StHalt: begin
               if (qd && qd_low) begin
                  state <= StExec;
                  run   <= 1'b1;
                  t     <= 3'b001;
               end
            end
            StExec: begin
               if (beat_end) begin
                  w <= w_nxt;
                  if (done) begin
                     cyc <= cyc + 1'b1;
                  end
                  if (stop || (done && step)) begin
                     state <= StHalt;
                     run   <= 1'b0;
                     t     <= 3'b000;
                  end else begin
                     t <= 3'b001;
                  end
               end else begin
                  t <= {t[1:0], 1'b0};
               end
            end
            default: begin
               state <= StHalt;
               run   <= 1'b0;
               t     <= 3'b000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Randomised bench for beat_timing_gen: a phase/beat/counter model built from integer
// counts is compared every cycle, plus directed scenarios with literal expectations.
module tb_beat_timing_gen;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       qd = 1'b0;
   logic       step = 1'b0;
   logic       short = 1'b0;
   logic       long = 1'b0;
   logic       stop = 1'b0;
   logic [2:0] t;
   logic [2:0] w;
   logic       run;
   logic [7:0] cyc;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model state: phase 0..2, beat 1..3, cycle count modulo 256.
   bit         m_run = 1'b0;
   int         m_ph = 0;
   int         m_beat = 1;
   logic [7:0] m_cyc = 8'd0;
   bit         m_qd_prev_low = 1'b0;

   beat_timing_gen #(.CYC_W(8)) dut (
      .clk   (clk),
      .clr   (clr),
      .qd    (qd),
      .step  (step),
      .short (short),
      .long  (long),
      .stop  (stop),
      .t     (t),
      .w     (w),
      .run   (run),
      .cyc   (cyc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model advanced at each rising edge from the inputs seen there.
   always @(posedge clk) begin
      if (!clr) begin
         m_run = 1'b0;
         m_ph = 0;
         m_beat = 1;
         m_cyc = 8'd0;
         m_qd_prev_low = 1'b0;
      end else begin
         if (!m_run) begin
            if (qd && m_qd_prev_low) begin
               m_run = 1'b1;
               m_ph = 0;
            end
         end else if (m_ph < 2) begin
            m_ph = m_ph + 1;
         end else begin
            bit complete;
            complete = 1'b0;
            if (m_beat == 1) begin
               if (short) complete = 1'b1;
               else m_beat = 2;
            end else if (m_beat == 2) begin
               if (long) m_beat = 3;
               else begin
                  m_beat = 1;
                  complete = 1'b1;
               end
            end else begin
               m_beat = 1;
               complete = 1'b1;
            end
            if (complete) m_cyc = m_cyc + 8'd1;
            m_ph = 0;
            if (stop || (complete && step)) m_run = 1'b0;
         end
         m_qd_prev_low = !qd;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_t", {29'd0, t}, m_run ? (32'd1 << m_ph) : 32'd0);
         check("model_w", {29'd0, w}, 32'd1 << (m_beat - 1));
         check("model_run", {31'd0, run}, {31'd0, m_run});
         check("model_cyc", {24'd0, cyc}, {24'd0, m_cyc});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      clr = 1'b0;
      tick(2);
      clr = 1'b1;
   endtask

   task automatic start();
      qd = 1'b0;
      tick();
      qd = 1'b1;
      tick();
      qd = 1'b0;
   endtask

   initial begin
      int guard;
      // 1: reset with QD high, no start on release, start on fresh edge
      clr = 1'b0;
      qd = 1'b1;
      tick(2);
      chk_en = 1'b1;
      check("rst_t", {29'd0, t}, 32'h0);
      check("rst_w", {29'd0, w}, 32'h1);
      check("rst_run", {31'd0, run}, 32'h0);
      check("rst_cyc", {24'd0, cyc}, 32'h0);
      clr = 1'b1;
      tick(3);
      check("qd_held_no_start", {31'd0, run}, 32'h0);
      qd = 1'b0;
      tick();
      qd = 1'b1;
      tick();
      check("start_run", {31'd0, run}, 32'h1);
      check("start_t", {29'd0, t}, 32'h1);
      check("start_w", {29'd0, w}, 32'h1);
      // 2: normal cycles
      tick(6);
      check("normal_cyc1", {24'd0, cyc}, 32'd1);
      tick(6);
      check("normal_cyc2", {24'd0, cyc}, 32'd2);
      qd = 1'b0;
      // 3: long then short
      long = 1'b1;
      tick(9);
      check("long_cyc", {24'd0, cyc}, 32'd3);
      long = 1'b0;
      short = 1'b1;
      tick(3);
      check("short_cyc", {24'd0, cyc}, 32'd4);
      check("short_w", {29'd0, w}, 32'h1);
      short = 1'b0;
      // 4: STOP at end of W1
      do_reset();
      start();
      tick(2);
      check("pre_stop_t", {29'd0, t}, 32'h4);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_run", {31'd0, run}, 32'h0);
      check("stop_t", {29'd0, t}, 32'h0);
      check("stop_w", {29'd0, w}, 32'h2);
      check("stop_cyc", {24'd0, cyc}, 32'h0);
      start();
      check("resume_w", {29'd0, w}, 32'h2);
      tick(3);
      check("resume_cyc", {24'd0, cyc}, 32'h1);
      // 5: counter wrap with STEP
      do_reset();
      start();
      short = 1'b1;
      guard = 0;
      while (cyc != 8'd255 && guard < 2000) begin
         tick();
         guard++;
      end
      check("preset_255", {24'd0, cyc}, 32'd255);
      short = 1'b0;
      step = 1'b1;
      guard = 0;
      while (run && guard < 20) begin
         tick();
         guard++;
      end
      check("step_run", {31'd0, run}, 32'h0);
      check("wrap_cyc", {24'd0, cyc}, 32'h0);
      check("step_w", {29'd0, w}, 32'h1);
      start();
      tick(6);
      check("step_one_more_run", {31'd0, run}, 32'h0);
      check("step_one_more_cyc", {24'd0, cyc}, 32'h1);
      step = 1'b0;
      // 6: reset in W3 T2
      do_reset();
      long = 1'b1;
      start();
      tick(7);
      check("pre_clr_w", {29'd0, w}, 32'h4);
      check("pre_clr_t", {29'd0, t}, 32'h2);
      clr = 1'b0;
      tick();
      check("clr_w3_t", {29'd0, t}, 32'h0);
      check("clr_w3_w", {29'd0, w}, 32'h1);
      check("clr_w3_cyc", {24'd0, cyc}, 32'h0);
      clr = 1'b1;
      long = 1'b0;
      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         clr   = ($urandom_range(0, 199) != 0);
         qd    = ($urandom_range(0, 2) == 0);
         short = ($urandom_range(0, 3) == 0);
         long  = ($urandom_range(0, 1) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         step  = ($urandom_range(0, 7) == 0);
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
